uart_rx_fifo: RTL

Serial receive front end for the memory-mapped UART. Recovers 8N1 frames from the board `rxd` pin using 16x oversampling, checks start and stop bits, and buffers received bytes in a small show-ahead FIFO. The arbiter's UART register logic consumes bytes through a valid/pop handshake. The block sits directly upstream of the arbiter's UART status and data registers and runs on the divided CPU clock `c`.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - byte/status handshake between the UART receiver and its consumer
interface uart_rx_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       pop;
    logic       overrun;
    logic       frame_err;
    logic       clr_err;

    modport master (
        output data,
        output valid,
        output overrun,
        output frame_err,
        input  pop,
        input  clr_err
    );

    modport slave (
        input  data,
        input  valid,
        input  overrun,
        input  frame_err,
        output pop,
        output clr_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 receiver with 16x oversampling feeding a show-ahead byte FIFO
module uart_rx_fifo #(
    parameter int DIV        = 14,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxd,
    uart_rx_fifo_if.master  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                  rxd_meta_q;
    logic                  rxs_q;
    state_t                state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [3:0]            sample_q, sample_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    logic tick;
    logic push;
    logic fe_set;
    logic valid;
    logic full;
    logic pop_acc;
    logic push_acc;
    logic ovr_set;

    assign tick = (tick_cnt_q == TW'(DIV - 1));

    // Receiver FSM: mid-bit sampling on the 8th tick of start, then every 16th tick.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        sample_d   = tick ? sample_q + 4'd1 : sample_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push       = 1'b0;
        fe_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    sample_d   = 4'd0;
                end
            end
            START: begin
                if (tick && sample_q == 4'd7) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        sample_d = 4'd0;
                        bit_d    = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick && sample_q == 4'd15) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && sample_q == 4'd15) begin
                    push    = rxs_q;
                    fe_set  = ~rxs_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop is only honoured when a byte is present, which lets a full FIFO absorb a push.
    always_comb begin
        valid       = (count_q != '0);
        full        = (count_q == CW'(DEPTH));
        pop_acc     = bus.pop & valid;
        push_acc    = push & (~full | pop_acc);
        ovr_set     = push & full & ~pop_acc;
        head_d      = head_q + DEPTH_LOG2'(pop_acc);
        tail_d      = tail_q + DEPTH_LOG2'(push_acc);
        count_d     = count_q + CW'(push_acc) - CW'(pop_acc);
        overrun_d   = ovr_set | (overrun_q & ~bus.clr_err);
        frame_err_d = fe_set | (frame_err_q & ~bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q  <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            sample_q    <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxs_q       <= rxd_meta_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            sample_q    <= sample_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[tail_q] <= shift_q;
        end
    end

    assign bus.valid     = valid;
    assign bus.data      = valid ? mem_q[head_q] : 8'h00;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule
